keypad_operand_entry: RTL and testbench
=======================================

KEYPAD_OPERAND_ENTRY -- requirements
Module: keypad_operand_entry

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 500000, meaning the consecutive stable cycles required to accept a key press or a key release; legal range 2..1048575.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port key_code, input, 4 bits: hex digit from the keypad scanner, held valid while a key is down.
REQ-005 SHALL have port key_hit, input, 1 bit: raw (undebounced) level, high while any key is down.
REQ-006 SHALL have port op_a, output, 16 bits: half-precision operand A.
REQ-007 SHALL have port op_b, output, 16 bits: half-precision operand B.
REQ-008 SHALL have port op_valid, output, 1 bit: op_a and op_b form a complete pair.
REQ-009 SHALL have port op_ready, input, 1 bit: the downstream adder accepts the pair.
REQ-010 SHALL have port digit_cnt, output, 2 bits: number of digits entered into the current operand.
REQ-011 SHALL have port disp, output, 16 bits: echo of the entry register for the 7-segment display.

Function
REQ-012 Debounce SHALL keep a stable level and a 20-bit counter.
- key_hit != stable: counter increments.
- Counter at DEB_CYCLES-1: stable takes key_hit and counter clears on that edge.
- key_hit == stable: counter clears.
REQ-013 A press event SHALL be the edge where stable goes 0->1; key_code SHALL be sampled on that edge only, giving exactly one digit per press however long the key is held.
REQ-014 A glitch on key_hit shorter than DEB_CYCLES cycles SHALL produce no event; a new press needs a debounced release first.
REQ-015 The FSM SHALL have states ENTER_A, ENTER_B and PRESENT; the reset state is ENTER_A.
REQ-016 In ENTER_A or ENTER_B, each press event SHALL do both of the following on the same edge:
- entry <= {entry[11:0], key_code};
- digit_cnt increments.
REQ-017 On the 4th digit in ENTER_A, the shifted value SHALL load op_a, entry and digit_cnt SHALL clear, and the FSM SHALL go to ENTER_B.
REQ-018 On the 4th digit in ENTER_B, the shifted value SHALL load op_b, entry and digit_cnt SHALL clear, the FSM SHALL go to PRESENT, and op_valid SHALL be 1 on the next cycle.
REQ-019 In PRESENT, op_valid SHALL be held high and op_a and op_b held stable until op_valid && op_ready.
REQ-020 On the op_valid && op_ready edge, the FSM SHALL go to ENTER_A and op_valid SHALL drop; op_a and op_b keep their values.
REQ-021 Press events occurring in PRESENT, including the transfer cycle, SHALL be discarded; debounce tracking SHALL continue.
REQ-022 op_ready while op_valid is 0 SHALL have no effect.
REQ-023 digit_cnt SHALL wrap 3->0 only through REQ-017 or REQ-018, and SHALL never read 4.

Reset
REQ-024 On rst=1 at a clock edge, all of the following SHALL be cleared to 0: stable, the counter, entry, digit_cnt, op_a, op_b, op_valid and disp; the FSM SHALL go to ENTER_A.
REQ-025 Reset mid-entry or in PRESENT SHALL abandon the partial entry or pending pair with no handshake.
REQ-026 If key_hit is held high through reset, it SHALL be debounced afresh after reset and SHALL yield one press event.

Configuration
REQ-027 With macro KEYPAD_OPERAND_ECHO_EN defined, disp SHALL be registered as follows:
- in ENTER_A or ENTER_B: entry;
- in PRESENT: op_b;
- updated on the same edge as the source.
REQ-028 Without KEYPAD_OPERAND_ECHO_EN, disp SHALL be tied to 16'h0000 and no echo register SHALL exist; all other behaviour is identical.

Verification (DEB_CYCLES=4)
REQ-029 Hold key_hit=1 with key_code=4'h3 for 3 cycles, then release -> no digit; digit_cnt=0.
REQ-030 Hold key 4'hA for 40 cycles -> exactly one digit; entry=16'h000A; entry updates 4 cycles after key_hit rises.
REQ-031 Press 3,C,0,0 then 4,1,0,0 with op_ready=0 -> op_a=16'h3C00, op_b=16'h4100, op_valid=1 and stays 1; an extra press of 7 is ignored.
REQ-032 From the REQ-031 state, assert op_ready for one cycle -> op_valid=0 next cycle, FSM in ENTER_A, op_a and op_b unchanged.
REQ-033 Press 1,2 then pulse rst -> digit_cnt=0, entry=0, op_a=0, op_valid=0; with KEYPAD_OPERAND_ECHO_EN, disp=16'h0012 before reset and 16'h0000 after.
REQ-034 Rebuild without KEYPAD_OPERAND_ECHO_EN and rerun REQ-031 -> identical operands; disp=0 throughout.

Source files
------------

// File: rtl/keypad_operand_entry.sv
// keypad_operand_entry
//   Collects two 4-digit hex operands from a keypad scanner and presents them
//   as a valid/ready pair to a downstream half-precision adder.
//
//   Parameters
//     DEB_CYCLES : consecutive stable cycles needed to accept a press or a
//                  release (2..1048575)
//
//   Ports
//     clk       : clock, rising edge
//     rst       : synchronous active-high reset
//     key_code  : hex digit from the scanner, valid while a key is down
//     key_hit   : raw level, high while any key is down
//     op_a      : operand A
//     op_b      : operand B
//     op_valid  : op_a/op_b form a complete pair
//     op_ready  : downstream accepts the pair
//     digit_cnt : digits entered into the current operand
//     disp      : entry echo for the 7-segment display
//
//   Build option
//     KEYPAD_OPERAND_ECHO_EN : when defined, disp is a registered echo of the
//                              entry register (op_b while presenting);
//                              otherwise disp is tied to zero.
module keypad_operand_entry #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key_code,
  input  logic        key_hit,
  output logic [15:0] op_a,
  output logic [15:0] op_b,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [1:0]  digit_cnt,
  output logic [15:0] disp
);

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    PRESENT = 2'd2
  } state_t;

  localparam logic [19:0] DEB_LAST = 20'(DEB_CYCLES - 1);

  state_t      state;
  logic        stable;
  logic [19:0] deb_cnt;
  logic [15:0] entry;
  logic [15:0] shifted;
  logic        accept;
  logic        press;
  logic        last_digit;

  // A press is the edge on which the debounced level rises, so the digit is
  // taken in the same cycle the debouncer accepts the new level.
  always_comb begin
    accept     = (key_hit != stable) && (deb_cnt == DEB_LAST);
    press      = accept && key_hit;
    shifted    = {entry[11:0], key_code};
    last_digit = (digit_cnt == 2'd3);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable  <= 1'b0;
      deb_cnt <= '0;
    end else if (key_hit != stable) begin
      if (accept) begin
        stable  <= key_hit;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 20'd1;
      end
    end else begin
      deb_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ENTER_A;
      entry     <= '0;
      digit_cnt <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_valid  <= 1'b0;
    end else begin
      case (state)
        ENTER_A, ENTER_B: begin
          if (press) begin
            if (last_digit) begin
              entry     <= '0;
              digit_cnt <= '0;
              if (state == ENTER_A) begin
                op_a  <= shifted;
                state <= ENTER_B;
              end else begin
                op_b     <= shifted;
                op_valid <= 1'b1;
                state    <= PRESENT;
              end
            end else begin
              entry     <= shifted;
              digit_cnt <= digit_cnt + 2'd1;
            end
          end
        end
        PRESENT: begin
          if (op_valid && op_ready) begin
            op_valid <= 1'b0;
            state    <= ENTER_A;
          end
        end
        default: begin
          state <= ENTER_A;
        end
      endcase
    end
  end

`ifdef KEYPAD_OPERAND_ECHO_EN
  // Echo tracks the next value of its source so it changes on the same edge:
  // entry while entering, op_b while presenting. entry is always zero in
  // PRESENT, so leaving PRESENT echoes zero.
  logic [15:0] disp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q <= '0;
    end else if (state == PRESENT) begin
      disp_q <= (op_valid && op_ready) ? entry : op_b;
    end else if (press) begin
      if (last_digit)
        disp_q <= (state == ENTER_B) ? shifted : '0;
      else
        disp_q <= shifted;
    end else begin
      disp_q <= entry;
    end
  end

  assign disp = disp_q;
`else
  assign disp = '0;
`endif

endmodule

// File: tb/tb_keypad_operand_entry.sv
module tb_keypad_operand_entry;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  key_code;
  logic        key_hit;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        op_valid;
  logic        op_ready;
  logic [1:0]  digit_cnt;
  logic [15:0] disp;

  int total = 0;
  int bad   = 0;

  keypad_operand_entry #(.DEB_CYCLES(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_code  (key_code),
    .key_hit   (key_hit),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .digit_cnt (digit_cnt),
    .disp      (disp)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Press, hold long enough to register, release long enough to debounce.
  task automatic press(input logic [3:0] code);
    key_code = code;
    key_hit  = 1'b1;
    tick(DEB + 2);
    key_hit  = 1'b0;
    tick(DEB + 2);
  endtask

  function automatic logic [15:0] echo(input logic [15:0] v);
`ifdef KEYPAD_OPERAND_ECHO_EN
    return v;
`else
    return 16'h0000 & v;
`endif
  endfunction

  initial begin
    rst      = 1'b1;
    key_code = 4'h0;
    key_hit  = 1'b0;
    op_ready = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);

    check("rst_valid", {15'd0, op_valid}, 16'h0000);
    check("rst_cnt",   {14'd0, digit_cnt}, 16'h0000);
    check("rst_opa",   op_a, 16'h0000);
    check("rst_opb",   op_b, 16'h0000);
    check("rst_disp",  disp, 16'h0000);

    // Short glitch (3 cycles) yields no digit; op_ready while idle is ignored.
    op_ready = 1'b1;
    key_code = 4'h3;
    key_hit  = 1'b1;
    tick(3);
    key_hit  = 1'b0;
    tick(6);
    check("glitch_cnt",   {14'd0, digit_cnt}, 16'h0000);
    check("glitch_disp",  disp, 16'h0000);
    check("idle_ready_v", {15'd0, op_valid}, 16'h0000);
    op_ready = 1'b0;

    // Long hold: one digit, landing on the 4th edge after key_hit rises.
    key_code = 4'hA;
    key_hit  = 1'b1;
    tick(3);
    check("hold_before", {14'd0, digit_cnt}, 16'h0000);
    tick(1);
    check("hold_edge4",  {14'd0, digit_cnt}, 16'h0001);
    check("hold_disp",   disp, echo(16'h000A));
    tick(36);
    check("hold_once",   {14'd0, digit_cnt}, 16'h0001);
    key_hit = 1'b0;
    tick(6);

    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    check("rst2_cnt", {14'd0, digit_cnt}, 16'h0000);

    // Operand A
    press(4'h3); press(4'hC); press(4'h0);
    check("a3_cnt",  {14'd0, digit_cnt}, 16'h0003);
    check("a3_disp", disp, echo(16'h03C0));
    press(4'h0);
    check("a_opa",   op_a, 16'h3C00);
    check("a_cnt",   {14'd0, digit_cnt}, 16'h0000);
    check("a_valid", {15'd0, op_valid}, 16'h0000);

    // Operand B
    press(4'h4); press(4'h1); press(4'h0); press(4'h0);
    check("b_opa",   op_a, 16'h3C00);
    check("b_opb",   op_b, 16'h4100);
    check("b_valid", {15'd0, op_valid}, 16'h0001);
    check("b_cnt",   {14'd0, digit_cnt}, 16'h0000);
    check("b_disp",  disp, echo(16'h4100));
    tick(10);
    check("b_hold",  {15'd0, op_valid}, 16'h0001);

    // Extra press while presenting is discarded.
    press(4'h7);
    check("x_opb",   op_b, 16'h4100);
    check("x_opa",   op_a, 16'h3C00);
    check("x_cnt",   {14'd0, digit_cnt}, 16'h0000);
    check("x_valid", {15'd0, op_valid}, 16'h0001);

    // Handshake
    op_ready = 1'b1;
    tick(1);
    op_ready = 1'b0;
    check("hs_valid", {15'd0, op_valid}, 16'h0000);
    check("hs_opa",   op_a, 16'h3C00);
    check("hs_opb",   op_b, 16'h4100);
    check("hs_disp",  disp, 16'h0000);

    // Back in ENTER_A: next four digits land in op_a.
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    check("na_opa",   op_a, 16'h1234);
    check("na_opb",   op_b, 16'h4100);
    check("na_valid", {15'd0, op_valid}, 16'h0000);

    // Partial entry abandoned by reset.
    press(4'h1); press(4'h2);
    check("p_cnt",  {14'd0, digit_cnt}, 16'h0002);
    check("p_disp", disp, echo(16'h0012));
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("pr_cnt",   {14'd0, digit_cnt}, 16'h0000);
    check("pr_opa",   op_a, 16'h0000);
    check("pr_opb",   op_b, 16'h0000);
    check("pr_valid", {15'd0, op_valid}, 16'h0000);
    check("pr_disp",  disp, 16'h0000);

    // Key held through reset is debounced afresh and gives one press.
    key_code = 4'h9;
    key_hit  = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(3);
    check("hr_before", {14'd0, digit_cnt}, 16'h0000);
    tick(1);
    check("hr_press",  {14'd0, digit_cnt}, 16'h0001);
    check("hr_disp",   disp, echo(16'h0009));
    tick(20);
    check("hr_once",   {14'd0, digit_cnt}, 16'h0001);
    key_hit = 1'b0;
    tick(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
